assoc_cache_controller: RTL and testbench

Parametrised two-way set-associative read cache that sits between the pipeline memory stage and the SRAM controller. Lines are LINE_WORDS words, filled in 64-bit SRAM beats. Writes are write-through, no-write-allocate, and write hits update the cached word. Adds a flush input and hit/miss counters; per-set LRU replacement.

---
 rtl/assoc_cache_controller.sv | 181 ++++++++++++++++++
 tb/tb_assoc_cache_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache_controller.sv
// rtl/assoc_cache_controller.sv - two-way set-associative read cache with write-through, flush and hit/miss counters
module assoc_cache_controller #(
  parameter int ADDR_W     = 19,
  parameter int INDEX_W    = 6,
  parameter int LINE_WORDS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        rdEn,
  input  logic        wrEn,
  input  logic        flush,
  output logic [31:0] readData,
  output logic        ready,
  output logic [31:0] sramAddress,
  output logic [31:0] sramWriteData,
  output logic        sramRdEn,
  output logic        sramWrEn,
  input  logic [63:0] sramReadData,
  input  logic        sramReady,
  output logic [31:0] hitCount,
  output logic [31:0] missCount
);

  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WOFF_W + 2;
  localparam int SETS   = 1 << INDEX_W;
  localparam int TAG_W  = ADDR_W - OFF_W - INDEX_W;
  localparam int BEATS  = LINE_WORDS / 2;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                victim_q, victim_d;
  logic                retry_q, retry_d;
  logic [SETS-1:0]     valid0_q, valid0_d;
  logic [SETS-1:0]     valid1_q, valid1_d;
  logic [SETS-1:0]     lru_q, lru_d;
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;

  logic [31:0]         data_mem [2][SETS][LINE_WORDS];
  logic [TAG_W-1:0]    tag_mem  [2][SETS];

  logic [WOFF_W-1:0]   offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic                hit0, hit1, hit, hit_way;
  logic                last_beat;
  logic [WOFF_W-1:0]   lo_word, hi_word;
  logic                fill_we, wr_we;

  assign offset    = address[OFF_W-1:2];
  assign index     = address[OFF_W+INDEX_W-1:OFF_W];
  assign tag       = address[ADDR_W-1:OFF_W+INDEX_W];
  assign hit0      = valid0_q[index] && (tag_mem[0][index] == tag);
  assign hit1      = valid1_q[index] && (tag_mem[1][index] == tag);
  assign hit       = hit0 || hit1;
  assign hit_way   = hit1;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign lo_word   = WOFF_W'({beat_q, 1'b0});
  assign hi_word   = WOFF_W'({beat_q, 1'b1});

  assign readData      = hit0 ? data_mem[0][index][offset] :
                         hit1 ? data_mem[1][index][offset] : 32'd0;
  assign sramRdEn      = (state_q == FILL);
  assign sramWrEn      = (state_q == WRITE);
  assign sramWriteData = writeData;
  assign sramAddress   = (state_q == WRITE) ? address :
                         {address[31:OFF_W], {OFF_W{1'b0}}} + 32'({beat_q, 3'b000});
  assign hitCount      = hit_cnt_q;
  assign missCount     = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    victim_d   = victim_q;
    retry_d    = 1'b0;
    valid0_d   = valid0_q;
    valid1_d   = valid1_q;
    lru_d      = lru_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    fill_we    = 1'b0;
    wr_we      = 1'b0;
    ready      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wrEn) begin
          state_d = WRITE;
        end else if (rdEn) begin
          if (hit) begin
            ready        = 1'b1;
            lru_d[index] = ~hit_way;
            // the retry after a fill was already counted as a miss
            if (!retry_q) hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            if (!valid0_q[index])      victim_d = 1'b0;
            else if (!valid1_q[index]) victim_d = 1'b1;
            else                       victim_d = lru_q[index];
            if (victim_d) valid1_d[index] = 1'b0;
            else          valid0_d[index] = 1'b0;
            beat_d     = '0;
            miss_cnt_d = miss_cnt_q + 32'd1;
            state_d    = FILL;
          end
        end else begin
          ready = 1'b1;
          if (flush) begin
            valid0_d = '0;
            valid1_d = '0;
          end
        end
      end
      FILL: begin
        if (sramReady) begin
          fill_we = 1'b1;
          if (last_beat) begin
            if (victim_q) valid1_d[index] = 1'b1;
            else          valid0_d[index] = 1'b1;
            lru_d[index] = ~victim_q;
            retry_d      = 1'b1;
            beat_d       = '0;
            state_d      = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (sramReady) begin
          ready = 1'b1;
          if (hit) begin
            wr_we        = 1'b1;
            lru_d[index] = ~hit_way;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      victim_q   <= 1'b0;
      retry_q    <= 1'b0;
      valid0_q   <= '0;
      valid1_q   <= '0;
      lru_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      victim_q   <= victim_d;
      retry_q    <= retry_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      lru_q      <= lru_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // line storage is not reset; valid bits gate every use of it
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[victim_q][index][lo_word] <= sramReadData[31:0];
      data_mem[victim_q][index][hi_word] <= sramReadData[63:32];
      if (last_beat) tag_mem[victim_q][index] <= tag;
    end
    if (wr_we) data_mem[hit_way][index][offset] <= writeData;
  end

endmodule

// File: tb/tb_assoc_cache_controller.sv
// tb/tb_assoc_cache_controller.sv - directed self-checking bench for assoc_cache_controller
module tb_assoc_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        rdEn, wrEn, flush;
  logic [63:0] sramReadData;
  logic        sramReady;
  logic        sel;

  logic [31:0] rd2, sa2, swd2, hc2, mc2;
  logic        rdy2, sre2, swe2;
  logic [31:0] rd4, sa4, swd4, hc4, mc4;
  logic        rdy4, sre4, swe4;

  logic        rd_en2, wr_en2, flush2, srdy2;
  logic        rd_en4, wr_en4, flush4, srdy4;

  logic [31:0] o_rd, o_sa, o_swd, o_hc, o_mc;
  logic        o_rdy, o_sre, o_swe;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rd_en2 = rdEn & ~sel;
  assign wr_en2 = wrEn & ~sel;
  assign flush2 = flush & ~sel;
  assign srdy2  = sramReady & ~sel;
  assign rd_en4 = rdEn & sel;
  assign wr_en4 = wrEn & sel;
  assign flush4 = flush & sel;
  assign srdy4  = sramReady & sel;

  assign o_rd  = sel ? rd4  : rd2;
  assign o_rdy = sel ? rdy4 : rdy2;
  assign o_sa  = sel ? sa4  : sa2;
  assign o_swd = sel ? swd4 : swd2;
  assign o_sre = sel ? sre4 : sre2;
  assign o_swe = sel ? swe4 : swe2;
  assign o_hc  = sel ? hc4  : hc2;
  assign o_mc  = sel ? mc4  : mc2;

  assoc_cache_controller #(.ADDR_W(19), .INDEX_W(6), .LINE_WORDS(2)) u_dut (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .rdEn(rd_en2), .wrEn(wr_en2), .flush(flush2),
    .readData(rd2), .ready(rdy2), .sramAddress(sa2), .sramWriteData(swd2),
    .sramRdEn(sre2), .sramWrEn(swe2), .sramReadData(sramReadData), .sramReady(srdy2),
    .hitCount(hc2), .missCount(mc2)
  );

  assoc_cache_controller #(.ADDR_W(19), .INDEX_W(6), .LINE_WORDS(4)) u_dut4 (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .rdEn(rd_en4), .wrEn(wr_en4), .flush(flush4),
    .readData(rd4), .ready(rdy4), .sramAddress(sa4), .sramWriteData(swd4),
    .sramRdEn(sre4), .sramWrEn(swe4), .sramReadData(sramReadData), .sramReady(srdy4),
    .hitCount(hc4), .missCount(mc4)
  );

  task automatic check_eq(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tg, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", o_rdy, 1);
    check_eq("rst_sre", o_sre, 0);
    check_eq("rst_hits", o_hc, 0);
    check_eq("rst_miss", o_mc, 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic read_hit(input string tg, input logic [31:0] addr, input logic [31:0] exp);
    address = addr;
    rdEn = 1'b1;
    @(negedge clk);
    check_eq({tg, "_ready"}, o_rdy, 1);
    check_eq({tg, "_data"}, o_rd, exp);
    check_eq({tg, "_sre"}, o_sre, 0);
    @(posedge clk); #1;
    rdEn = 1'b0;
  endtask

  task automatic read_miss(input string tg, input logic [31:0] addr, input logic [31:0] base,
                           input int nb, input logic [63:0] b0, input logic [63:0] b1,
                           input logic [31:0] exp, input int lat);
    address = addr;
    rdEn = 1'b1;
    @(negedge clk);
    check_eq({tg, "_idle_ready"}, o_rdy, 0);
    @(posedge clk); #1;
    for (int b = 0; b < nb; b++) begin
      for (int w = 0; w < lat; w++) begin
        @(negedge clk);
        check_eq({tg, "_wait_addr"}, o_sa, 32'(base + 8 * b));
        check_eq({tg, "_wait_ready"}, o_rdy, 0);
        @(posedge clk); #1;
      end
      @(negedge clk);
      check_eq({tg, "_sre"}, o_sre, 1);
      check_eq({tg, "_saddr"}, o_sa, 32'(base + 8 * b));
      sramReadData = (b == 0) ? b0 : b1;
      sramReady = 1'b1;
      @(posedge clk); #1;
      sramReady = 1'b0;
    end
    @(negedge clk);
    check_eq({tg, "_retry_ready"}, o_rdy, 1);
    check_eq({tg, "_retry_data"}, o_rd, exp);
    @(posedge clk); #1;
    rdEn = 1'b0;
  endtask

  task automatic cpu_write(input string tg, input logic [31:0] addr, input logic [31:0] data);
    address = addr;
    writeData = data;
    wrEn = 1'b1;
    @(negedge clk);
    check_eq({tg, "_idle_ready"}, o_rdy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({tg, "_swe"}, o_swe, 1);
    check_eq({tg, "_saddr"}, o_sa, addr);
    check_eq({tg, "_sdata"}, o_swd, data);
    check_eq({tg, "_wait_ready"}, o_rdy, 0);
    sramReady = 1'b1;
    #1;
    check_eq({tg, "_ready"}, o_rdy, 1);
    @(posedge clk); #1;
    sramReady = 1'b0;
    wrEn = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    address = '0;
    writeData = '0;
    rdEn = 1'b0;
    wrEn = 1'b0;
    flush = 1'b0;
    sramReadData = '0;
    sramReady = 1'b0;
    sel = 1'b0;

    do_reset();
    read_miss("m100", 32'h100, 32'h100, 1, 64'hBBBBBBBB_AAAAAAAA, 64'h0, 32'hAAAAAAAA, 2);
    read_hit("h104", 32'h104, 32'hBBBBBBBB);
    @(negedge clk);
    check_eq("cnt1_hits", o_hc, 1);
    check_eq("cnt1_miss", o_mc, 1);
    @(posedge clk); #1;

    read_miss("m300", 32'h300, 32'h300, 1, 64'h00000301_00000300, 64'h0, 32'h300, 0);
    read_hit("h100a", 32'h100, 32'hAAAAAAAA);
    read_miss("m500", 32'h500, 32'h500, 1, 64'h00000501_00000500, 64'h0, 32'h500, 1);
    read_hit("h100b", 32'h100, 32'hAAAAAAAA);
    read_miss("m300b", 32'h300, 32'h300, 1, 64'h00000311_00000310, 64'h0, 32'h310, 0);
    read_hit("h504none_h100", 32'h104, 32'hBBBBBBBB);
    @(negedge clk);
    check_eq("cnt2_hits", o_hc, 4);
    check_eq("cnt2_miss", o_mc, 4);
    @(posedge clk); #1;

    cpu_write("w104", 32'h104, 32'h12345678);
    read_hit("h104w", 32'h104, 32'h12345678);
    cpu_write("w900", 32'h900, 32'hCAFEF00D);
    read_miss("m900", 32'h900, 32'h900, 1, 64'h00000901_00000900, 64'h0, 32'h900, 0);
    read_hit("h100c", 32'h100, 32'hAAAAAAAA);
    @(negedge clk);
    check_eq("cnt3_hits", o_hc, 6);
    check_eq("cnt3_miss", o_mc, 5);
    @(posedge clk); #1;

    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    read_miss("mflush", 32'h100, 32'h100, 1, 64'hDDDDDDDD_CCCCCCCC, 64'h0, 32'hCCCCCCCC, 0);
    read_hit("hflush", 32'h104, 32'hDDDDDDDD);

    sel = 1'b1;
    do_reset();
    read_miss("l4m48", 32'h48, 32'h40, 2, 64'h00000001_00000000, 64'h00000003_00000002, 32'h2, 1);
    read_hit("l4h44", 32'h44, 32'h1);
    read_hit("l4h4c", 32'h4C, 32'h3);

    address = 32'h80;
    rdEn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("abort_b0_addr", o_sa, 32'h80);
    sramReadData = 64'h00000011_00000010;
    sramReady = 1'b1;
    @(posedge clk); #1;
    sramReady = 1'b0;
    @(negedge clk);
    check_eq("abort_b1_sre", o_sre, 1);
    check_eq("abort_b1_addr", o_sa, 32'h88);
    rst = 1'b0;
    #1;
    check_eq("abort_sre_drop", o_sre, 0);
    rdEn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    read_miss("abort_reread", 32'h80, 32'h80, 2, 64'h00000021_00000020, 64'h00000023_00000022, 32'h20, 0);
    @(negedge clk);
    check_eq("abort_miss_cnt", o_mc, 1);
    check_eq("abort_hit_cnt", o_hc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
